ka116_seq: RTL and testbench
============================

KA116_SEQ -- requirements
Module: ka116_seq

Interface
REQ-001 SHALL have parameter N, default 116, operand width in bits; only 116 is supported.
REQ-002 SHALL have parameter H, default 58, half-operand width; SHALL equal N/2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand pair A/B is offered.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 A  input  116  multiplicand, a polynomial over GF(2); bit i is the coefficient of x^i.
REQ-008 B  input  116  multiplier, same encoding as A.
REQ-009 out_valid  output  1  O holds a finished product.
REQ-010 out_ready  input  1  consumer accepts O.
REQ-011 O  output  231  carry-less product A*B over GF(2).
REQ-012 op_cnt  output  16  count of products delivered.

Function
REQ-013 SHALL contain exactly one 58x58 carry-less Karatsuba core (115-bit result), time-shared over three half-products.
REQ-014 SHALL implement FSM states IDLE, LO, HI, MID, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; in_valid SHALL be ignored in all other states.
REQ-016 IDLE, in_valid=1: register A and B, go to LO.
REQ-017 LO: core operands Al=A[57:0], Bl=B[57:0]; register result as T0; go to HI.
REQ-018 HI: core operands Au=A[115:58], Bu=B[115:58]; register result as T1; go to MID.
REQ-019 MID: core operands Al^Au and Bl^Bu, giving T2.
REQ-020 MID: register O = {T1,116'b0} ^ {58'b0,(T0^T1^T2),58'b0} ^ {116'b0,T0}; go to DONE.
REQ-021 All arithmetic SHALL be XOR (no carries); widths SHALL be exact with no truncation.
REQ-022 DONE: out_valid=1; O SHALL stay stable while out_ready=0, for any length of stall.
REQ-023 DONE, out_ready=1: go to IDLE, drop out_valid next cycle, increment op_cnt by 1.
REQ-024 op_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-025 Latency: out_valid SHALL rise exactly 4 cycles after the accepting edge (in_valid & in_ready).
REQ-026 Throughput SHALL be at most one product per 5 cycles with out_ready tied high.
REQ-027 O SHALL retain the last product after leaving DONE until the next MID.
REQ-028 Registered A/B SHALL not change between accept and DONE, whatever in_valid/A/B do.

Reset
REQ-029 rst=1 at any clock edge, including mid-operation, SHALL force state IDLE next cycle.
REQ-030 Same reset edge SHALL clear out_valid=0, O=0, op_cnt=0, T0=T1=T2=0.
REQ-031 After reset in_ready SHALL be 1; a product aborted by reset SHALL never be emitted or counted.
REQ-032 rst SHALL take priority over in_valid and out_ready on the same edge.

Verification
REQ-033 Identity: A=1, B=1, out_ready=1 -> O=1, out_valid 4 cycles after accept, op_cnt=1.
REQ-034 Carry-less and cross terms:
- A=3, B=3 -> O=5.
- A=B=2^58+1 -> O=2^116+1.
REQ-035 Top bit: A=B=2^115 -> O=2^230.
REQ-036 All ones:
- A=B=all ones -> O has bits 0,2,...,230 set, odd bits clear.
- Random A/B vs. a shift-XOR reference model: 10k pairs match.
REQ-037 Back-pressure and protocol:
- Hold out_ready=0 for 20 cycles in DONE -> O stable, in_ready=0, op_cnt unchanged.
- Then release out_ready -> op_cnt increments exactly once.
- Toggle in_valid/A/B while busy -> result unaffected.
REQ-038 Reset mid-op: assert rst in HI -> next cycle IDLE, O=0, out_valid=0, op_cnt=0; a new product then completes correctly.

Source files
------------

// File: rtl/ka116_seq.sv
// Sequential 116x116 carry-less multiplier: one 58x58 Karatsuba core reused for the low, high and middle half-products.
// out_valid is high four cycles after the accept cycle; O and out_valid hold while out_ready is low.
module ka116_seq #(
  parameter int N = 116,
  parameter int H = 58
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-2:0]   O,
  output logic [15:0]      op_cnt
);

  localparam int Q = H / 2;

  typedef enum logic [2:0] {IDLE, LO, HI, MID, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [2*H-2:0] t0_q, t0_d, t1_q, t1_d, t2;
  logic [2*N-2:0] o_q, o_d;
  logic [15:0]    cnt_q, cnt_d;

  logic [H-1:0]   core_x, core_y;
  logic [2*H-2:0] core_p;
  logic [2*Q-2:0] p0, p1, p2;

  function automatic logic [2*Q-2:0] clmul_q(input logic [Q-1:0] x, input logic [Q-1:0] y);
    logic [2*Q-2:0] r;
    r = '0;
    for (int i = 0; i < Q; i++) begin
      if (y[i]) r = r ^ ({{(Q-1){1'b0}}, x} << i);
    end
    return r;
  endfunction

  // One-level Karatsuba inside the core: three 29x29 products make the 58x58 one.
  always_comb begin
    p0     = clmul_q(core_x[Q-1:0], core_y[Q-1:0]);
    p1     = clmul_q(core_x[H-1:Q], core_y[H-1:Q]);
    p2     = clmul_q(core_x[Q-1:0] ^ core_x[H-1:Q], core_y[Q-1:0] ^ core_y[H-1:Q]);
    core_p = {p1, {(2*Q){1'b0}}}
           ^ {{Q{1'b0}}, p0 ^ p1 ^ p2, {Q{1'b0}}}
           ^ {{(2*Q){1'b0}}, p0};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    t0_d      = t0_q;
    t1_d      = t1_q;
    o_d       = o_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    core_x    = a_q[H-1:0];
    core_y    = b_q[H-1:0];
    t2        = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          state_d = LO;
        end
      end
      LO: begin
        t0_d    = core_p;
        state_d = HI;
      end
      HI: begin
        core_x  = a_q[N-1:H];
        core_y  = b_q[N-1:H];
        t1_d    = core_p;
        state_d = MID;
      end
      MID: begin
        // T2 only exists during MID; it is folded straight into O.
        core_x  = a_q[H-1:0] ^ a_q[N-1:H];
        core_y  = b_q[H-1:0] ^ b_q[N-1:H];
        t2      = core_p;
        o_d     = {t1_q, {N{1'b0}}}
                ^ {{H{1'b0}}, t0_q ^ t1_q ^ t2, {H{1'b0}}}
                ^ {{N{1'b0}}, t0_q};
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      o_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
    end
  end

  assign O      = o_q;
  assign op_cnt = cnt_q;

endmodule

// File: tb/tb_ka116_seq.sv
// Scoreboarded bench for ka116_seq against a shift-XOR polynomial product model.
module tb_ka116_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [115:0] A, B;
  logic         out_valid;
  logic         out_ready;
  logic [230:0] O;
  logic [15:0]  op_cnt;

  always #5 clk = ~clk;

  ka116_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .O(O), .op_cnt(op_cnt)
  );

  int           total = 0;
  int           bad = 0;
  logic [230:0] exp_q[$];
  logic [15:0]  exp_cnt = 16'd0;
  int           cyc = 0;
  int           acc_cyc = 0;
  logic         prev_ov = 1'b0;
  int           rdy_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [230:0] act, input logic [230:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [230:0] ref_mul(input logic [115:0] a, input logic [115:0] b);
    logic [230:0] r;
    r = '0;
    for (int i = 0; i < 116; i++)
      if (b[i]) r = r ^ ({115'b0, a} << i);
    return r;
  endfunction

  function automatic logic [115:0] rand116();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[115:0];
  endfunction

  // Monitor: picks out_ready for the coming edge, then scores any handshake that edge will complete.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (!rst) begin
      if (out_valid && !prev_ov) check("latency", cyc - acc_cyc, 231'd4);
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0h with nothing outstanding", O);
        end else begin
          check("product", O, exp_q.pop_front());
          check("op_cnt", {215'b0, op_cnt}, {215'b0, exp_cnt});
          exp_cnt++;
        end
      end
    end else begin
      prev_ov = 1'b0;
    end
  end

  // Drives garbage while the block is busy, then offers the pair once in_ready rises.
  task automatic send(input logic [115:0] a, input logic [115:0] b, input logic [230:0] e);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      in_valid = 1'($urandom_range(0, 1));
      A = rand116();
      B = rand116();
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles, need 1", in_ready, n);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1;
    A = a;
    B = b;
    acc_cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain", exp_q.size(), 231'd0);
    check("op_cnt_drain", {215'b0, op_cnt}, {215'b0, exp_cnt});
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [115:0] v, ra, rb;
    logic [230:0] e, o0;
    logic [15:0]  c0;
    logic         ok;
    int           n;

    rst = 1'b1;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {230'b0, in_ready}, 231'd1);
    check("rst_out_valid", {230'b0, out_valid}, 231'd0);
    check("rst_O", O, 231'd0);
    check("rst_op_cnt", {215'b0, op_cnt}, 231'd0);
    rst = 1'b0;

    send(116'd1, 116'd1, 231'd1);
    drain();
    check("ident_cnt", {215'b0, op_cnt}, 231'd1);

    send(116'd3, 116'd3, 231'd5);
    v = '0; v[58] = 1'b1; v[0] = 1'b1;
    e = '0; e[116] = 1'b1; e[0] = 1'b1;
    send(v, v, e);
    v = '0; v[115] = 1'b1;
    e = '0; e[230] = 1'b1;
    send(v, v, e);
    v = '1;
    e = '0;
    for (int i = 0; i <= 230; i += 2) e[i] = 1'b1;
    send(v, v, e);
    drain();

    // Stall in DONE with busy-time garbage on the inputs.
    rdy_mode = 0;
    ra = rand116();
    rb = rand116();
    send(ra, rb, ref_mul(ra, rb));
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_reach_done", {230'b0, out_valid}, 231'd1);
    o0 = O;
    c0 = op_cnt;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      A = rand116();
      B = rand116();
      if (O !== o0 || in_ready !== 1'b0 || op_cnt !== c0 || out_valid !== 1'b1) ok = 1'b0;
    end
    check("stall_stable", {230'b0, ok}, 231'd1);
    in_valid = 1'b0;
    rdy_mode = 1;
    drain();
    check("stall_release_cnt", {215'b0, op_cnt}, {215'b0, c0 + 16'd1});

    // Abort in HI.
    ra = rand116();
    rb = rand116();
    send(ra, rb, ref_mul(ra, rb));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", {230'b0, in_ready}, 231'd1);
    check("midrst_out_valid", {230'b0, out_valid}, 231'd0);
    check("midrst_O", O, 231'd0);
    check("midrst_op_cnt", {215'b0, op_cnt}, 231'd0);
    exp_q.delete();
    exp_cnt = 16'd0;
    rst = 1'b0;
    ra = rand116();
    rb = rand116();
    send(ra, rb, ref_mul(ra, rb));
    drain();

    rdy_mode = 2;
    for (int k = 0; k < 10000; k++) begin
      ra = rand116();
      rb = rand116();
      send(ra, rb, ref_mul(ra, rb));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
